// File: rtl/tarot_msg_sender.sv
// tarot_msg_sender: formats a card index as two ASCII digits (+ optional CR LF)
// and feeds the bytes to a UART transmitter over a start/done handshake.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   card_valid   card_idx valid this cycle
//   card_idx     7-bit card index
//   card_ready   high only in IDLE (combinational)
//   tx_start     one-cycle pulse, UART loads tx_byte
//   tx_byte      byte to send, held until tx_done
//   tx_done      one-cycle pulse from UART, byte sent
//   msg_done     one-cycle pulse after the final tx_done
module tarot_msg_sender #(
  parameter int NUM_CARDS = 78,
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       card_valid,
  input  logic [6:0] card_idx,
  output logic       card_ready,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  output logic       msg_done
);

  typedef enum logic [1:0] {
    IDLE, CONV, START, WAIT
  } state_t;

  localparam logic [6:0] LIMIT = 7'(NUM_CARDS);
  localparam logic [1:0] LAST  = SEND_CRLF ? 2'd3 : 2'd1;

  state_t     state;
  logic [6:0] idx_q;
  logic [7:0] d1_q;
  logic [7:0] d0_q;
  logic [1:0] cnt;

  logic [6:0] rem;
  logic [3:0] tens;
  logic [7:0] d1_c;
  logic [7:0] d0_c;
  logic [1:0] cnt_nx;
  logic [7:0] byte_nx;

  // Repeated subtract-by-ten; nine steps cover 0..99.
  always_comb begin
    rem  = idx_q;
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    if (idx_q >= LIMIT) begin
      d1_c = 8'h45;
      d0_c = 8'h52;
    end else begin
      d1_c = 8'h30 + {4'h0, tens};
      d0_c = 8'h30 + {1'b0, rem};
    end
  end

  always_comb begin
    cnt_nx = cnt + 2'd1;
    unique case (cnt_nx)
      2'd0:    byte_nx = d1_q;
      2'd1:    byte_nx = d0_q;
      2'd2:    byte_nx = 8'h0D;
      default: byte_nx = 8'h0A;
    endcase
  end

  assign card_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx_q    <= 7'd0;
      d1_q     <= 8'h00;
      d0_q     <= 8'h00;
      cnt      <= 2'd0;
      tx_start <= 1'b0;
      tx_byte  <= 8'h00;
      msg_done <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      msg_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (card_valid) begin
            idx_q <= card_idx;
            state <= CONV;
          end
        end
        CONV: begin
          d1_q     <= d1_c;
          d0_q     <= d0_c;
          cnt      <= 2'd0;
          tx_byte  <= d1_c;
          tx_start <= 1'b1;
          state    <= START;
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            if (cnt == LAST) begin
              msg_done <= 1'b1;
              state    <= IDLE;
            end else begin
              cnt      <= cnt_nx;
              tx_byte  <= byte_nx;
              tx_start <= 1'b1;
              state    <= START;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tarot_msg_sender.sv
// Testbench for tarot_msg_sender: scoreboard of expected bytes,
// UART responder model, and a second instance without CR LF.
module tb_tarot_msg_sender;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       card_valid = 1'b0;
  logic [6:0] card_idx = 7'd0;
  logic       card_ready;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_done = 1'b0;
  logic       msg_done;

  logic       cv1 = 1'b0;
  logic [6:0] ci1 = 7'd0;
  logic       cr1;
  logic       ts1;
  logic [7:0] tb1;
  logic       td1 = 1'b0;
  logic       md1;

  always #5 clk = ~clk;

  tarot_msg_sender #(.NUM_CARDS(78), .SEND_CRLF(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .card_valid(card_valid), .card_idx(card_idx),
    .card_ready(card_ready), .tx_start(tx_start),
    .tx_byte(tx_byte), .tx_done(tx_done),
    .msg_done(msg_done)
  );

  tarot_msg_sender #(.NUM_CARDS(78), .SEND_CRLF(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .card_valid(cv1), .card_idx(ci1),
    .card_ready(cr1), .tx_start(ts1),
    .tx_byte(tb1), .tx_done(td1),
    .msg_done(md1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int msgs = 0;
  int first_start_cyc = -1;
  int last_start = -1;
  int dly = 2;
  bit every = 1'b0;
  bit busy = 1'b0;
  logic [7:0] held = 8'h00;
  logic [7:0] exp_q[$];

  task automatic chk(input string n, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", n, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: pops the scoreboard on each tx_start, checks hold and spacing.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      busy = 1'b0;
      last_start = -1;
    end else begin
      if (tx_start) begin
        starts++;
        if (first_start_cyc < 0) first_start_cyc = cyc;
        if (every && last_start >= 0)
          chk("start_spacing", cyc - last_start, 2);
        last_start = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte got %0d required none", tx_byte);
        end else begin
          chk("tx_byte", int'(tx_byte), int'(exp_q.pop_front()));
        end
        held = tx_byte;
        busy = 1'b1;
      end else if (busy) begin
        chk("byte_hold", int'(tx_byte), int'(held));
        if (tx_done) busy = 1'b0;
      end
      if (msg_done) begin
        msgs++;
        last_start = -1;
      end
    end
  end

  // UART model: one-cycle tx_done dly cycles after each tx_start.
  initial forever begin
    @(negedge clk);
    if (rst_n && tx_start && !every) begin
      repeat (dly) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
    end
  end

  task automatic send(input logic [6:0] idx, input logic [7:0] a,
                      input logic [7:0] b, input bit inject);
    int base_s;
    int base_m;
    int acc;
    int n;
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    base_s = starts;
    base_m = msgs;
    n = 0;
    while (!card_ready && n < 50) begin
      tick();
      n++;
    end
    chk("ready_idle", int'(card_ready), 1);
    card_valid = 1'b1;
    card_idx = idx;
    acc = cyc;
    first_start_cyc = -1;
    tick();
    card_valid = 1'b0;
    card_idx = 7'd0;
    if (inject) begin
      n = 0;
      while (starts == base_s && n < 50) begin
        tick();
        n++;
      end
      chk("ready_in_wait", int'(card_ready), 0);
      card_valid = 1'b1;
      card_idx = 7'd5;
      tick();
      card_valid = 1'b0;
      card_idx = 7'd0;
    end
    n = 0;
    while (msgs == base_m && n < 300) begin
      tick();
      n++;
    end
    chk("msg_done_count", msgs - base_m, 1);
    repeat (8) tick();
    chk("start_count", starts - base_s, 4);
    chk("queue_empty", exp_q.size(), 0);
    chk("first_latency", first_start_cyc - acc, 2);
  endtask

  logic [7:0] exp1 [2];

  initial begin
    int n;
    int base_s;
    int s1;
    int m1;
    exp1[0] = 8'h30;
    exp1[1] = 8'h37;

    #2;
    chk("rst_ready", int'(card_ready), 1);
    chk("rst_start", int'(tx_start), 0);
    chk("rst_byte", int'(tx_byte), 0);
    chk("rst_msg", int'(msg_done), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    send(7'd7, 8'h30, 8'h37, 1'b0);
    send(7'd77, 8'h37, 8'h37, 1'b0);
    send(7'd0, 8'h30, 8'h30, 1'b0);
    send(7'd78, 8'h45, 8'h52, 1'b0);
    send(7'd127, 8'h45, 8'h52, 1'b0);
    dly = 3;
    send(7'd9, 8'h30, 8'h39, 1'b1);
    dly = 1;
    send(7'd19, 8'h31, 8'h39, 1'b0);

    every = 1'b1;
    tx_done = 1'b1;
    send(7'd55, 8'h35, 8'h35, 1'b0);
    send(7'd12, 8'h31, 8'h32, 1'b0);
    tx_done = 1'b0;
    every = 1'b0;
    dly = 2;
    repeat (3) tick();

    exp_q.push_back(8'h33);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    base_s = starts;
    card_valid = 1'b1;
    card_idx = 7'd33;
    tick();
    card_valid = 1'b0;
    card_idx = 7'd0;
    n = 0;
    while (starts < base_s + 2 && n < 100) begin
      tick();
      n++;
    end
    chk("abort_starts_before", starts - base_s, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ready", int'(card_ready), 1);
    chk("async_start", int'(tx_start), 0);
    chk("async_byte", int'(tx_byte), 0);
    chk("async_msg", int'(msg_done), 0);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("abort_no_more", starts - base_s, 2);
    send(7'd42, 8'h34, 8'h32, 1'b0);

    s1 = 0;
    m1 = 0;
    cv1 = 1'b1;
    ci1 = 7'd7;
    tick();
    cv1 = 1'b0;
    ci1 = 7'd0;
    for (int i = 0; i < 40; i++) begin
      if (md1) m1++;
      if (ts1) begin
        if (s1 < 2) chk("nocrlf_byte", int'(tb1), int'(exp1[s1]));
        s1++;
        tick();
        td1 = 1'b1;
        tick();
        td1 = 1'b0;
      end else begin
        tick();
      end
    end
    chk("nocrlf_starts", s1, 2);
    chk("nocrlf_msgs", m1, 1);
    chk("nocrlf_ready", int'(cr1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
